// File: rtl/mem_access_stage_pkg.sv
// Shared CPU definitions for the MEM stage: FSM state encodings and the poison value for abandoned loads.
// Pure declarations, no logic, no latency or flow control of its own.
package mem_access_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [31:0] BAD_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Bus-wait watchdog: counts enabled cycles; expire_o flags the cycle in which the count reaches TIMEOUT.
// expire_o is combinational from the count; clr_i has priority over en_i; never stalls anything itself.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = 8'd0;
    end else if (en_i) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // The increment happening this cycle is the one that reaches TIMEOUT.
  assign expire_o = en_i && (count_q == LAST);

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: non-memory ops pass through in zero cycles; loads/stores take >=3 cycles over a req/ack bus.
// Backpressure: stall holds the front of the pipe for the whole access; the stage emits bubbles meanwhile.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              reg_write_in,
  input  logic              mem_to_reg_in,
  input  logic [REG_W-1:0]  dest_reg_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] store_data_in,
  output logic              bus_req,
  output logic              bus_we,
  output logic [DATA_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              stall,
  output logic              reg_write_out,
  output logic              mem_to_reg_out,
  output logic [REG_W-1:0]  dest_reg_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] mem_read_data_out,
  output logic              mem_err
);

  state_e            state_q;
  logic              bus_req_q;
  logic              bus_we_q;
  logic [DATA_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              fault_q;
  logic              mem_err_q;

  logic mem_op;
  logic misal;
  logic expire;

  assign mem_op = mem_read_in | mem_write_in;
  assign misal  = mem_op & (alu_result_in[1:0] != 2'b00);

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_q != WAIT),
    .en_i     (state_q == WAIT),
    .expire_o (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      fault_q     <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      mem_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (misal) begin
            state_q   <= DONE;
            fault_q   <= 1'b1;
            mem_err_q <= 1'b1;
          end else if (mem_op) begin
            state_q     <= WAIT;
            bus_req_q   <= 1'b1;
            bus_we_q    <= mem_write_in;
            bus_addr_q  <= alu_result_in;
            bus_wdata_q <= store_data_in;
          end
        end
        WAIT: begin
          // Ack beats a simultaneous timeout; stores never touch rdata_q, even when abandoned.
          if (bus_ack) begin
            if (!bus_we_q) rdata_q <= bus_rdata;
            bus_req_q <= 1'b0;
            state_q   <= DONE;
          end else if (expire) begin
            if (!bus_we_q) rdata_q <= DATA_W'(BAD_DATA);
            bus_req_q <= 1'b0;
            mem_err_q <= 1'b1;
            fault_q   <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
          fault_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    stall             = 1'b0;
    reg_write_out     = 1'b0;
    mem_to_reg_out    = 1'b0;
    dest_reg_out      = '0;
    alu_result_out    = '0;
    mem_read_data_out = '0;
    if ((state_q == IDLE && mem_op) || state_q == WAIT) begin
      stall = 1'b1;
    end else begin
      // EX/MEM is frozen during the access, so DONE still sees the original instruction.
      reg_write_out     = reg_write_in & ~((state_q == DONE) & fault_q);
      mem_to_reg_out    = mem_to_reg_in;
      dest_reg_out      = dest_reg_in;
      alu_result_out    = alu_result_in;
      mem_read_data_out = rdata_q;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage with TIMEOUT=4: directed vector table, random instruction stream, reset mid-access.
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in;
  logic [4:0]  dest_reg_in;
  logic [31:0] alu_result_in, store_data_in;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        stall, reg_write_out, mem_to_reg_out, mem_err;
  logic [4:0]  dest_reg_out;
  logic [31:0] alu_result_out, mem_read_data_out;

  always #5 clk = ~clk;

  mem_access_stage #(.DATA_W(32), .REG_W(5), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
    .dest_reg_in(dest_reg_in), .alu_result_in(alu_result_in), .store_data_in(store_data_in),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .stall(stall), .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out),
    .dest_reg_out(dest_reg_out), .alu_result_out(alu_result_out),
    .mem_read_data_out(mem_read_data_out), .mem_err(mem_err)
  );

  typedef struct {
    logic        rd, wr, rw, m2r;
    logic [4:0]  dest;
    logic [31:0] addr, wdata;
    int          ack_at;     // WAIT cycle (1-based) carrying the ack; 0 = never
    logic [31:0] ack_data;
    int          e_stall, e_req;
    logic        e_err, e_rw;
    logic [31:0] e_rdata;
  } vec_t;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] rmodel  = 32'h0;   // expected content of the stage's load-data register

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic rd, wr, rw, m2r, input logic [4:0] dest,
                              input logic [31:0] addr, wdata, input int ack_at,
                              input logic [31:0] ack_data, input int e_stall, e_req,
                              input logic e_err, e_rw, input logic [31:0] e_rdata);
    vec_t v;
    v.rd = rd; v.wr = wr; v.rw = rw; v.m2r = m2r; v.dest = dest;
    v.addr = addr; v.wdata = wdata; v.ack_at = ack_at; v.ack_data = ack_data;
    v.e_stall = e_stall; v.e_req = e_req; v.e_err = e_err; v.e_rw = e_rw; v.e_rdata = e_rdata;
    return v;
  endfunction

  // Presents one instruction until the stage releases it; expected trace is derived
  // from the instruction alone: 1 cycle, misaligned 2 cycles, else IDLE + WAITs + DONE.
  task automatic run_instr(input vec_t v, input bit noise, output int n_stall, output int n_req,
                           output int n_err, output logic rw_done, output logic [31:0] rd_done);
    bit mem, mis, to, is_load;
    int nw, total;
    logic [31:0] rnew;
    mem = v.rd | v.wr;
    mis = mem && (v.addr[1:0] != 2'b00);
    is_load = mem && !mis && !v.wr;
    to = 1'b0;
    nw = 0;
    if (!mem) total = 1;
    else if (mis) total = 2;
    else begin
      to = (v.ack_at < 1) || (v.ack_at > TO);
      nw = to ? TO : v.ack_at;
      total = nw + 2;
    end
    rnew = rmodel;
    if (is_load) rnew = to ? 32'hDEAD_BEEF : v.ack_data;
    n_stall = 0; n_req = 0; n_err = 0; rw_done = 1'b0; rd_done = 32'h0;
    mem_read_in = v.rd; mem_write_in = v.wr; reg_write_in = v.rw; mem_to_reg_in = v.m2r;
    dest_reg_in = v.dest; alu_result_in = v.addr; store_data_in = v.wdata;
    for (int c = 0; c < total; c++) begin
      bit done, req_e, err_e;
      done = (c == total - 1);
      if (mem && !mis && !to && c == v.ack_at) begin
        bus_ack = 1'b1; bus_rdata = v.ack_data;
      end else if (noise && (c == 0 || done)) begin
        bus_ack = 1'b1; bus_rdata = $urandom;
      end else begin
        bus_ack = 1'b0; bus_rdata = $urandom;
      end
      @(negedge clk);
      req_e = mem && !mis && c >= 1 && c <= nw;
      err_e = done && (mis || to);
      if (done) rmodel = rnew;
      chk($sformatf("stall@%0d", c), stall, !done);
      chk($sformatf("bus_req@%0d", c), bus_req, req_e);
      chk($sformatf("mem_err@%0d", c), mem_err, err_e);
      chk($sformatf("reg_write@%0d", c), reg_write_out, done && v.rw && !(mis || to));
      chk($sformatf("mem_to_reg@%0d", c), mem_to_reg_out, done && v.m2r);
      chk($sformatf("dest@%0d", c), dest_reg_out, done ? v.dest : 5'd0);
      chk($sformatf("alu@%0d", c), alu_result_out, done ? v.addr : 32'h0);
      chk($sformatf("rdata@%0d", c), mem_read_data_out, done ? rnew : 32'h0);
      if (req_e) begin
        chk($sformatf("bus_we@%0d", c), bus_we, v.wr);
        chk($sformatf("bus_addr@%0d", c), bus_addr, v.addr);
        chk($sformatf("bus_wdata@%0d", c), bus_wdata, v.wdata);
      end
      if (stall) n_stall++;
      if (bus_req) n_req++;
      if (mem_err) n_err++;
      if (done) begin rw_done = reg_write_out; rd_done = mem_read_data_out; end
      @(posedge clk); #1;
    end
    bus_ack = 1'b0;
  endtask

  vec_t        tbl[6];
  vec_t        rv;
  int          ns, nr, ne;
  logic        rwd;
  logic [31:0] rdd;

  initial begin
    rst = 1'b1; bus_ack = 1'b0; bus_rdata = 32'h0;
    mem_read_in = 1'b0; mem_write_in = 1'b0; reg_write_in = 1'b0; mem_to_reg_in = 1'b0;
    dest_reg_in = 5'd0; alu_result_in = 32'h0; store_data_in = 32'h0;

    tbl[0] = mk(0, 0, 1, 0, 5'd3, 32'h10,  32'h0,  0, 32'h0,         0, 0, 0, 1, 32'h0);
    tbl[1] = mk(1, 0, 1, 1, 5'd7, 32'h100, 32'h0,  3, 32'hCAFE_0001, 4, 3, 0, 1, 32'hCAFE_0001);
    tbl[2] = mk(0, 1, 0, 0, 5'd0, 32'h204, 32'h55, 1, 32'h0,         2, 1, 0, 0, 32'hCAFE_0001);
    tbl[3] = mk(1, 0, 1, 1, 5'd9, 32'h102, 32'h0,  2, 32'h0,         1, 0, 1, 0, 32'hCAFE_0001);
    tbl[4] = mk(1, 0, 1, 1, 5'd4, 32'h300, 32'h0,  0, 32'h0,         5, 4, 1, 0, 32'hDEAD_BEEF);
    tbl[5] = mk(1, 0, 1, 1, 5'd5, 32'h304, 32'h0,  4, 32'h1234,      5, 4, 0, 1, 32'h1234);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_bus_req", bus_req, 1'b0);
    chk("rst_bus_we", bus_we, 1'b0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    chk("rst_mem_err", mem_err, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_rdata", mem_read_data_out, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_instr(tbl[i], 1'b0, ns, nr, ne, rwd, rdd);
      chk($sformatf("tbl%0d_stall_cycles", i), ns, tbl[i].e_stall);
      chk($sformatf("tbl%0d_req_cycles", i), nr, tbl[i].e_req);
      chk($sformatf("tbl%0d_err_pulses", i), ne, tbl[i].e_err ? 1 : 0);
      chk($sformatf("tbl%0d_done_rw", i), rwd, tbl[i].e_rw);
      chk($sformatf("tbl%0d_done_rdata", i), rdd, tbl[i].e_rdata);
    end

    for (int i = 0; i < 150; i++) begin
      int op;
      op = $urandom_range(2);
      rv.rd = (op == 1); rv.wr = (op == 2);
      rv.rw = 1'($urandom); rv.m2r = 1'($urandom); rv.dest = 5'($urandom);
      rv.addr = $urandom;
      if ($urandom_range(3) != 0) rv.addr[1:0] = 2'b00;
      rv.wdata = $urandom; rv.ack_at = $urandom_range(6); rv.ack_data = $urandom;
      run_instr(rv, 1'($urandom), ns, nr, ne, rwd, rdd);
    end

    // Reset during WAIT, then a late ack with a non-memory instruction presented.
    mem_read_in = 1'b1; mem_write_in = 1'b0; reg_write_in = 1'b1; mem_to_reg_in = 1'b1;
    dest_reg_in = 5'd2; alu_result_in = 32'h400; bus_ack = 1'b0;
    @(negedge clk);
    chk("rstw_idle_stall", stall, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstw_wait_req", bus_req, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_read_in = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h999;
    rmodel = 32'h0;
    @(negedge clk);
    chk("rstw_req_cleared", bus_req, 1'b0);
    chk("rstw_stall", stall, 1'b0);
    chk("rstw_rdata", mem_read_data_out, 32'h0);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    chk("rstw_late_ack_req", bus_req, 1'b0);
    chk("rstw_late_ack_stall", stall, 1'b0);
    chk("rstw_late_ack_err", mem_err, 1'b0);
    chk("rstw_late_ack_rdata", mem_read_data_out, 32'h0);
    @(posedge clk); #1;

    // Counter must restart from zero after the reset: 3-cycle ack must not time out.
    rv = mk(1, 0, 1, 0, 5'd8, 32'h500, 32'h0, 3, 32'hABCD_0003, 4, 3, 0, 1, 32'hABCD_0003);
    run_instr(rv, 1'b0, ns, nr, ne, rwd, rdd);
    chk("post_rst_err_pulses", ne, 0);
    chk("post_rst_rdata", rdd, 32'hABCD_0003);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
